// File: rtl/rv32i_singlecycle.sv
// Single-cycle RV32I core: fetch, decode, execute, memory access and writeback all commit on one rising edge.
// Instruction memory has no write port; the environment preloads `imem` with the image named by IMEM_INIT_FILE.
module rv32i_singlecycle #(
    parameter int IMEM_ADDR_BIT  = 10,
    parameter int DMEM_ADDR_BIT  = 10,
    parameter     IMEM_INIT_FILE = "riscv_program.mif"
) (
    input logic i_clk,
    input logic i_rstn
);
    localparam int IMEM_WORDS = 2 ** (IMEM_ADDR_BIT - 2);
    localparam int DMEM_WORDS = 2 ** (DMEM_ADDR_BIT - 2);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {WB_ALU, WB_LOAD, WB_LINK, WB_LUI, WB_AUIPC} wb_sel_t;
    typedef enum logic [1:0] {PC_PLUS4, PC_REL, PC_JALR} pc_sel_t;

    logic [31:0] imem      [IMEM_WORDS];
    logic [31:0] registers [32];
    logic [31:0] dmem_arr  [DMEM_WORDS];

    logic [31:0] pc, pc_plus4, next_pc, instr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        funct7_alt;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, target_imm;

    logic        reg_we, mem_we, use_imm, is_reg_op, branch_taken, load_ok;
    wb_sel_t     wb_sel;
    pc_sel_t     pc_sel;
    logic [31:0] alu_b, alu_result, wb_data;
    logic [4:0]  shamt;

    logic [DMEM_ADDR_BIT-1:0] mem_addr;
    logic [31:0] dmem_word, load_data, store_data;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [3:0]  byte_en;

    assign instr      = imem[pc[IMEM_ADDR_BIT-1:2]];
    assign opcode     = instr[6:0];
    assign rd         = instr[11:7];
    assign funct3     = instr[14:12];
    assign rs1        = instr[19:15];
    assign rs2        = instr[24:20];
    assign funct7_alt = instr[30];

    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : registers[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : registers[rs2];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        case (funct3)
            3'b000:  branch_taken = (rs1_val == rs2_val);
            3'b001:  branch_taken = (rs1_val != rs2_val);
            3'b100:  branch_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  branch_taken = (rs1_val <  rs2_val);
            3'b111:  branch_taken = (rs1_val >= rs2_val);
            default: branch_taken = 1'b0;
        endcase
    end

    assign load_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010)
                  || (funct3 == 3'b100) || (funct3 == 3'b101);

    // Anything not decoded below (including FENCE/SYSTEM) falls out as a NOP.
    always_comb begin
        reg_we     = 1'b0;
        mem_we     = 1'b0;
        use_imm    = 1'b1;
        is_reg_op  = 1'b0;
        wb_sel     = WB_ALU;
        pc_sel     = PC_PLUS4;
        target_imm = imm_b;
        case (opcode)
            OP_LUI:   begin reg_we = 1'b1; wb_sel = WB_LUI; end
            OP_AUIPC: begin reg_we = 1'b1; wb_sel = WB_AUIPC; end
            OP_JAL: begin
                reg_we     = 1'b1;
                wb_sel     = WB_LINK;
                pc_sel     = PC_REL;
                target_imm = imm_j;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    reg_we = 1'b1;
                    wb_sel = WB_LINK;
                    pc_sel = PC_JALR;
                end
            end
            OP_BRANCH: if (branch_taken) pc_sel = PC_REL;
            OP_LOAD:   begin reg_we = load_ok; wb_sel = WB_LOAD; end
            OP_STORE:  mem_we = (funct3 < 3'b011);
            OP_IMM:    reg_we = 1'b1;
            OP_REG:    begin reg_we = 1'b1; use_imm = 1'b0; is_reg_op = 1'b1; end
            default: ;
        endcase
    end

    assign alu_b = use_imm ? imm_i : rs2_val;
    assign shamt = alu_b[4:0];

    // On OP-IMM, instr[30] is imm bit 10, which is exactly the SRAI marker.
    always_comb begin
        case (funct3)
            3'b000:  alu_result = (is_reg_op && funct7_alt) ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001:  alu_result = rs1_val << shamt;
            3'b010:  alu_result = {31'd0, $signed(rs1_val) < $signed(alu_b)};
            3'b011:  alu_result = {31'd0, rs1_val < alu_b};
            3'b100:  alu_result = rs1_val ^ alu_b;
            3'b101:  alu_result = funct7_alt ? $unsigned($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
            3'b110:  alu_result = rs1_val | alu_b;
            default: alu_result = rs1_val & alu_b;
        endcase
    end

    assign mem_addr  = rs1_val[DMEM_ADDR_BIT-1:0]
                     + ((opcode == OP_STORE) ? imm_s[DMEM_ADDR_BIT-1:0] : imm_i[DMEM_ADDR_BIT-1:0]);
    assign dmem_word = dmem_arr[mem_addr[DMEM_ADDR_BIT-1:2]];
    assign load_half = mem_addr[1] ? dmem_word[31:16] : dmem_word[15:0];

    always_comb begin
        case (mem_addr[1:0])
            2'b00:   load_byte = dmem_word[7:0];
            2'b01:   load_byte = dmem_word[15:8];
            2'b10:   load_byte = dmem_word[23:16];
            default: load_byte = dmem_word[31:24];
        endcase
        case (funct3)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b010:  load_data = dmem_word;
            3'b100:  load_data = {24'd0, load_byte};
            3'b101:  load_data = {16'd0, load_half};
            default: load_data = 32'd0;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        case (funct3)
            3'b000: begin
                byte_en    = 4'b0001 << mem_addr[1:0];
                store_data = {4{rs2_val[7:0]}};
            end
            3'b001: begin
                byte_en    = mem_addr[1] ? 4'b1100 : 4'b0011;
                store_data = {2{rs2_val[15:0]}};
            end
            3'b010: begin
                byte_en    = 4'b1111;
                store_data = rs2_val;
            end
            default: begin
                byte_en    = 4'b0000;
                store_data = rs2_val;
            end
        endcase
    end

    always_comb begin
        case (wb_sel)
            WB_LOAD:  wb_data = load_data;
            WB_LINK:  wb_data = pc_plus4;
            WB_LUI:   wb_data = imm_u;
            WB_AUIPC: wb_data = pc + imm_u;
            default:  wb_data = alu_result;
        endcase
    end

    // JALR only reaches PC_JALR with funct3=000, where the ALU computes rs1+immI.
    assign pc_plus4 = pc + 32'd4;
    always_comb begin
        case (pc_sel)
            PC_REL:  next_pc = pc + target_imm;
            PC_JALR: next_pc = {alu_result[31:1], 1'b0};
            default: next_pc = pc_plus4;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rstn) begin
            pc <= 32'd0;
            for (int i = 0; i < 32; i++) registers[i] <= 32'd0;
        end else begin
            pc <= next_pc;
            if (reg_we && (rd != 5'd0)) registers[rd] <= wb_data;
        end
    end

    // Data memory is deliberately outside the reset domain.
    always_ff @(posedge i_clk) begin
        if (!i_rstn && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) dmem_arr[mem_addr[DMEM_ADDR_BIT-1:2]][8*b +: 8] <= store_data[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_rv32i_singlecycle.sv
// Bench for rv32i_singlecycle: directed programs plus random programs run in lockstep
// against an instruction-level model with a byte-addressed data memory.
module tb_rv32i_singlecycle;
    localparam int IMEM_WORDS = 256;
    localparam int DMEM_BYTES = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_imem  [IMEM_WORDS];
    logic [31:0] m_regs  [32];
    logic [7:0]  m_bytes [DMEM_BYTES];
    logic [31:0] m_pc;
    logic [31:0] exp_q[$];
    logic [31:0] prog[$];

    rv32i_singlecycle #(.IMEM_ADDR_BIT(10), .DMEM_ADDR_BIT(10)) dut (
        .i_clk (clk),
        .i_rstn(rst)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(int op, int rd, int f3, int rs1, int imm);
        logic [31:0] o, d, f, s, m;
        o = op; d = rd; f = f3; s = rs1; m = imm;
        return {m[11:0], s[4:0], f[2:0], d[4:0], o[6:0]};
    endfunction

    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        logic [31:0] a, t, s, f, d;
        a = f7; t = rs2; s = rs1; f = f3; d = rd;
        return {a[6:0], t[4:0], s[4:0], f[2:0], d[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(int f3, int rs2, int rs1, int imm);
        logic [31:0] f, t, s, m;
        f = f3; t = rs2; s = rs1; m = imm;
        return {m[11:5], t[4:0], s[4:0], f[2:0], m[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(int f3, int rs1, int rs2, int imm);
        logic [31:0] f, s, t, m;
        f = f3; s = rs1; t = rs2; m = imm;
        return {m[12], m[10:5], t[4:0], s[4:0], f[2:0], m[4:1], m[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(int op, int rd, int imm20);
        logic [31:0] o, d, m;
        o = op; d = rd; m = imm20;
        return {m[19:0], d[4:0], o[6:0]};
    endfunction

    function automatic logic [31:0] enc_j(int rd, int imm);
        logic [31:0] d, m;
        d = rd; m = imm;
        return {m[20], m[10:1], m[11], m[19:12], d[4:0], 7'h6F};
    endfunction

    function automatic logic [31:0] rand_instr();
        int kind, rd, rs1, rs2, f3, imm, tmp;
        int lf[5];
        int bf[6];
        lf = '{0, 1, 2, 4, 5};
        bf = '{0, 1, 4, 5, 6, 7};
        kind = $urandom_range(0, 10);
        rd   = $urandom_range(0, 7);
        rs1  = $urandom_range(0, 7);
        rs2  = $urandom_range(0, 7);
        f3   = $urandom_range(0, 7);
        imm  = $urandom_range(0, 4095);
        case (kind)
            0: return enc_u(32'h37, rd, $urandom_range(0, 32'hFFFFF));
            1: return enc_u(32'h17, rd, $urandom_range(0, 32'hFFFFF));
            2, 3: begin
                if (f3 == 1) imm = $urandom_range(0, 31);
                if (f3 == 5) imm = $urandom_range(0, 31) + ($urandom_range(0, 1) != 0 ? 32'h400 : 0);
                return enc_i(32'h13, rd, f3, rs1, imm);
            end
            4: return enc_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) != 0) ? 32'h20 : 0, rs2, rs1, f3, rd);
            5: return enc_i(32'h03, rd, lf[$urandom_range(0, 4)], rs1, imm);
            6: return enc_s($urandom_range(0, 2), rs2, rs1, imm);
            7: begin
                tmp = $urandom_range(0, 5);
                tmp = (tmp - 2) * 4;
                if (tmp == 0) tmp = 8;
                return enc_b(bf[$urandom_range(0, 5)], rs1, rs2, tmp);
            end
            8: return enc_j(rd, $urandom_range(1, 4) * 4);
            9: return enc_i(32'h67, rd, 0, rs1, $urandom_range(0, 63));
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] m_alu(logic [2:0] f3, logic alt, logic is_reg, logic [31:0] a, logic [31:0] b);
        case (f3)
            3'd0:    return (is_reg && alt) ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    endtask

    task automatic model_step();
        logic [31:0] ins, a, b, res, nxt, ea, imm_i, imm_s, imm_b, imm_u, imm_j;
        logic [9:0]  b0, b1, b2, b3;
        logic [15:0] half;
        logic [4:0]  rd;
        logic        wr, taken;
        ins   = m_imem[m_pc[9:2]];
        rd    = ins[11:7];
        a     = m_regs[ins[19:15]];
        b     = m_regs[ins[24:20]];
        imm_i = {{20{ins[31]}}, ins[31:20]};
        imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        imm_u = {ins[31:12], 12'h000};
        imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        wr = 1'b0; res = 32'd0; taken = 1'b0;
        nxt = m_pc + 32'd4;
        case (ins[6:0])
            7'h37: begin wr = 1'b1; res = imm_u; end
            7'h17: begin wr = 1'b1; res = m_pc + imm_u; end
            7'h6F: begin wr = 1'b1; res = m_pc + 32'd4; nxt = m_pc + imm_j; end
            7'h67: if (ins[14:12] == 3'd0) begin
                wr = 1'b1; res = m_pc + 32'd4; nxt = (a + imm_i) & ~32'd1;
            end
            7'h63: begin
                case (ins[14:12])
                    3'd0: taken = (a == b);
                    3'd1: taken = (a != b);
                    3'd4: taken = ($signed(a) < $signed(b));
                    3'd5: taken = ($signed(a) >= $signed(b));
                    3'd6: taken = (a < b);
                    3'd7: taken = (a >= b);
                    default: taken = 1'b0;
                endcase
                if (taken) nxt = m_pc + imm_b;
            end
            7'h03: begin
                ea = a + imm_i;
                b0 = ea[9:0];
                case (ins[14:12])
                    3'd0: begin wr = 1'b1; res = {{24{m_bytes[b0][7]}}, m_bytes[b0]}; end
                    3'd4: begin wr = 1'b1; res = {24'd0, m_bytes[b0]}; end
                    3'd1, 3'd5: begin
                        b0 = {ea[9:1], 1'b0}; b1 = b0 + 10'd1;
                        half = {m_bytes[b1], m_bytes[b0]};
                        wr = 1'b1;
                        res = (ins[14:12] == 3'd1) ? {{16{half[15]}}, half} : {16'd0, half};
                    end
                    3'd2: begin
                        b0 = {ea[9:2], 2'b00}; b1 = b0 + 10'd1; b2 = b0 + 10'd2; b3 = b0 + 10'd3;
                        wr = 1'b1;
                        res = {m_bytes[b3], m_bytes[b2], m_bytes[b1], m_bytes[b0]};
                    end
                    default: wr = 1'b0;
                endcase
            end
            7'h23: begin
                ea = a + imm_s;
                b0 = ea[9:0];
                case (ins[14:12])
                    3'd0: m_bytes[b0] = b[7:0];
                    3'd1: begin
                        b0 = {ea[9:1], 1'b0}; b1 = b0 + 10'd1;
                        m_bytes[b0] = b[7:0]; m_bytes[b1] = b[15:8];
                    end
                    3'd2: begin
                        b0 = {ea[9:2], 2'b00}; b1 = b0 + 10'd1; b2 = b0 + 10'd2; b3 = b0 + 10'd3;
                        m_bytes[b0] = b[7:0]; m_bytes[b1] = b[15:8];
                        m_bytes[b2] = b[23:16]; m_bytes[b3] = b[31:24];
                    end
                    default: ;
                endcase
            end
            7'h13: begin wr = 1'b1; res = m_alu(ins[14:12], ins[30], 1'b0, a, imm_i); end
            7'h33: begin wr = 1'b1; res = m_alu(ins[14:12], ins[30], 1'b1, a, b); end
            default: ;
        endcase
        if (wr && rd != 5'd0) m_regs[rd] = res;
        m_pc = nxt;
    endtask

    task automatic load_program();
        for (int i = 0; i < IMEM_WORDS; i++) begin
            m_imem[i] = (i < prog.size()) ? prog[i] : 32'd0;
            dut.imem[i] = m_imem[i];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else model_step();
        exp_q.push_back(m_pc);
        check("pc", dut.pc, exp_q.pop_front());
    endtask

    task automatic check_regs_zero(input string tag);
        for (int i = 0; i < 32; i++) check($sformatf("%s_x%0d", tag, i), dut.registers[i], 32'd0);
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < 32; i++) check($sformatf("%s_x%0d", tag, i), dut.registers[i], m_regs[i]);
        for (int w = 0; w < IMEM_WORDS; w++)
            check($sformatf("%s_dmem%0d", tag, w), dut.dmem_arr[w],
                  {m_bytes[4*w+3], m_bytes[4*w+2], m_bytes[4*w+1], m_bytes[4*w]});
    endtask

    initial begin
        for (int i = 0; i < DMEM_BYTES; i++) m_bytes[i] = 8'd0;
        model_reset();

        // Reset hold and basic ALU
        prog.delete();
        prog.push_back(enc_i(32'h13, 1, 0, 0, 5));
        prog.push_back(enc_i(32'h13, 2, 0, 0, -3));
        prog.push_back(enc_r(0, 2, 1, 0, 3));
        prog.push_back(enc_r(32'h20, 2, 1, 0, 4));
        prog.push_back(enc_r(0, 2, 1, 3, 5));
        rst = 1'b1;
        load_program();
        repeat (4) tick();
        check_regs_zero("reset");
        rst = 1'b0;
        check("pc_after_release", dut.pc, 32'h0);
        repeat (5) tick();
        check("alu_x1", dut.registers[1], 32'd5);
        check("alu_x2", dut.registers[2], 32'hFFFF_FFFD);
        check("alu_add", dut.registers[3], 32'd2);
        check("alu_sub", dut.registers[4], 32'd8);
        check("alu_sltu", dut.registers[5], 32'd1);
        compare_all("alu");

        // Shifts and logic
        prog.delete();
        prog.push_back(enc_u(32'h37, 1, 32'h80000));
        prog.push_back(enc_i(32'h13, 2, 5, 1, 32'h404));
        prog.push_back(enc_i(32'h13, 3, 5, 1, 4));
        prog.push_back(enc_i(32'h13, 4, 4, 0, -1));
        rst = 1'b1;
        load_program();
        repeat (2) tick();
        rst = 1'b0;
        repeat (4) tick();
        check("srai", dut.registers[2], 32'hF800_0000);
        check("srli", dut.registers[3], 32'h0800_0000);
        check("xori", dut.registers[4], 32'hFFFF_FFFF);
        compare_all("shift");

        // Loads/stores, then a reset landing on a pending store
        prog.delete();
        prog.push_back(enc_u(32'h37, 1, 32'h12345));
        prog.push_back(enc_i(32'h13, 1, 0, 1, 32'h687));
        prog.push_back(enc_s(2, 1, 0, 0));
        prog.push_back(enc_i(32'h03, 2, 0, 0, 0));
        prog.push_back(enc_i(32'h03, 3, 4, 0, 0));
        prog.push_back(enc_i(32'h03, 4, 1, 0, 2));
        prog.push_back(enc_s(0, 0, 0, 1));
        prog.push_back(enc_i(32'h03, 5, 2, 0, 0));
        prog.push_back(enc_s(2, 1, 0, 8));
        rst = 1'b1;
        load_program();
        repeat (2) tick();
        rst = 1'b0;
        repeat (8) tick();
        check("lb", dut.registers[2], 32'hFFFF_FF87);
        check("lbu", dut.registers[3], 32'h0000_0087);
        check("lh", dut.registers[4], 32'h0000_1234);
        check("lw_after_sb", dut.registers[5], 32'h1234_0087);
        check("dmem_word0", dut.dmem_arr[0], 32'h1234_0087);
        rst = 1'b1;
        tick();
        check("no_store_in_reset", dut.dmem_arr[2], 32'h0);
        check_regs_zero("rst_store");
        compare_all("mem");

        // Control flow, x0 writes and an unknown opcode
        prog.delete();
        prog.push_back(enc_b(0, 0, 0, 8));
        prog.push_back(enc_i(32'h13, 6, 0, 0, 1));
        prog.push_back(enc_b(1, 0, 0, 8));
        prog.push_back(enc_i(32'h13, 7, 0, 0, 2));
        prog.push_back(enc_i(32'h13, 0, 0, 0, 7));
        prog.push_back(32'hFFFF_FFFF);
        prog.push_back(enc_i(32'h13, 0, 0, 0, 0));
        prog.push_back(enc_i(32'h13, 0, 0, 0, 0));
        prog.push_back(enc_j(1, 12));
        prog.push_back(enc_i(32'h13, 8, 0, 0, 3));
        prog.push_back(enc_i(32'h13, 9, 0, 0, 4));
        prog.push_back(enc_i(32'h67, 2, 0, 1, 1));
        load_program();
        tick();
        rst = 1'b0;
        tick();
        check("beq_taken_pc", dut.pc, 32'h8);
        tick();
        check("bne_fallthrough_pc", dut.pc, 32'hC);
        repeat (2) tick();
        check("x0_stays_zero", dut.registers[0], 32'h0);
        tick();
        check("unknown_op_pc", dut.pc, 32'h18);
        compare_all("unknown_op");
        repeat (3) tick();
        check("jal_link", dut.registers[1], 32'h24);
        check("jal_pc", dut.pc, 32'h2C);
        tick();
        check("jalr_pc", dut.pc, 32'h24);
        check("jalr_link", dut.registers[2], 32'h30);
        check("skipped_x6", dut.registers[6], 32'h0);
        check("fallthrough_x7", dut.registers[7], 32'h2);
        repeat (6) tick();
        compare_all("ctrl");

        // Random programs with a reset after 20 instructions
        for (int r = 0; r < 3; r++) begin
            prog.delete();
            for (int k = 0; k < 48; k++) prog.push_back(rand_instr());
            rst = 1'b1;
            load_program();
            repeat (2) tick();
            rst = 1'b0;
            repeat (20) tick();
            compare_all($sformatf("rand%0d_a", r));
            rst = 1'b1;
            tick();
            check("midrun_reset_pc", dut.pc, 32'h0);
            check_regs_zero($sformatf("rand%0d_rst", r));
            compare_all($sformatf("rand%0d_rst", r));
            rst = 1'b0;
            repeat (40) tick();
            compare_all($sformatf("rand%0d_b", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rv32i_singlecycle.md
# rv32i_singlecycle

Single-cycle RV32I processor core: every instruction is fetched, decoded, executed and retired in one clock cycle. It sits at the top of the core hierarchy and contains the PC register, instruction memory, register file, immediate decoder, ALU, control unit and data memory. It has no functional outputs; state is observed hierarchically through the register file and data memory arrays.

## Interface
- IMEM_ADDR_BIT, 10: byte-address width of instruction memory (2^(IMEM_ADDR_BIT-2) words).
- DMEM_ADDR_BIT, 10: byte-address width of data memory (2^(DMEM_ADDR_BIT-2) words).
- IMEM_INIT_FILE, "riscv_program.mif": hex word image loaded into instruction memory at time 0 via $readmemh; words beyond the image read 0.
- i_clk  input  1  single clock; all state updates on the rising edge.
- i_rstn  input  1  reset, synchronous and active-high: i_rstn=1 at a rising edge resets the core.

## Operation
- Fetch: instruction = imem[pc[IMEM_ADDR_BIT-1:2]], combinational read. Address bits above IMEM_ADDR_BIT are ignored, so fetch wraps modulo memory size.
- Register file: 32x32 array `registers`. Two combinational read ports. One write port, written on the rising edge. x0 always reads 0 and writes to it are discarded.
- Immediates: sign-extended I, S, B, U and J formats per the RV32I spec.
- Supported instructions:
  - LUI, AUIPC.
  - JAL: rd = pc+4, pc = pc+immJ.
  - JALR: rd = pc+4, pc = (rs1+immI) & ~1.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU: taken -> pc+immB, else pc+4.
  - Loads: LB, LH, LW, LBU, LHU.
  - Stores: SB, SH, SW.
  - OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - OP: ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
- ALU: 32-bit arithmetic modulo 2^32. Shift amount is the low 5 bits. SLT/SLTU produce 0 or 1. SRA/SRAI replicate the sign bit.
- Data memory: word array `dmem_arr`, zero at time 0, never cleared by reset.
  - Address = rs1+immI (loads) or rs1+immS (stores), taken modulo memory size.
  - Read is combinational. LB/LH sign-extend, LBU/LHU zero-extend.
  - Stores use byte enables from addr[1:0]: SB writes one lane; SH writes the lane pair selected by addr[1]; SW writes the whole word.
  - Misaligned halfword/word accesses force the low address bits to alignment (addr[0] ignored for halfword, addr[1:0] ignored for word).
- Writeback source select: ALU result, load data, pc+4 (jumps), or immU / pc+immU.
- FENCE, ECALL, EBREAK, CSR and any illegal/unknown opcode act as NOP: no register or memory write, pc = pc+4.
- The next pc comes from a mux of pc+4, pc+imm (branch/JAL) and the JALR target. No exceptions are raised; misaligned jump targets are taken as is (with bit 0 cleared for JALR).

## Timing
- Reset (i_rstn=1 at an edge): pc <= 0, all 32 registers <= 0. No register-file or data-memory write occurs during a reset cycle. Reset asserted mid-program takes effect at the next edge, and execution restarts at address 0 on the first edge after release.
- Each non-reset rising edge retires exactly one instruction: the pc update, the rd write and the memory store all commit at that same edge.
- CPI = 1; no stalls, no pipeline, no hazards.
- A load followed by a dependent instruction sees the loaded value in the next cycle.
- A store followed by a load to the same address in the next cycle returns the stored data.
- A branch or jump target is fetched in the cycle after the branch.
- Simultaneous write to rd and read of the same register in one cycle returns the old value; the new value is visible from the next cycle.

## Test plan
- Reset/ALU: hold reset 4 cycles, then run `addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; sub x4,x1,x2; sltu x5,x1,x2` -> x3=2, x4=8, x5=1; pc=0 on the first cycle after release.
- Shifts/logic: x1=0x80000000 via `lui x1,0x80000`; `srai x2,x1,4; srli x3,x1,4; xori x4,x0,-1` -> x2=0xF8000000, x3=0x08000000, x4=0xFFFFFFFF.
- Memory: x1=0x12345687; `sw x1,0(x0); lb x2,0(x0); lbu x3,0(x0); lh x4,2(x0); sb x0,1(x0); lw x5,0(x0)` -> x2=0xFFFFFF87, x3=0x87, x4=0x1234, x5=0x12340087.
- Control flow: `beq x0,x0,+8` skips one instruction; `bne` with equal operands falls through; `jal x1,+12` at pc 0x20 -> x1=0x24, pc=0x2C; `jalr x2,x1,1` -> pc=0x24, x2=0x30.
- Writes to x0: `addi x0,x0,7` leaves x0=0. An unknown opcode (0xFFFFFFFF) changes no registers or memory and advances pc by 4.
- Mid-run reset after 20 instructions -> pc=0 and all registers 0 on the next edge; dmem_arr contents preserved.
